seg_scan_capture: RTL

//  Reads a time-multiplexed, active-low seven-segment display bus (segments + digit

---
 rtl/seg7_pkg.sv | 36 +++
 rtl/seg2hex.sv | 34 +++
 rtl/seg_scan_capture.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan capture path: active-low
// digit patterns (bit6=a .. bit0=g), FSM state encoding and decoder result type.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DWELL   = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] nib;
        logic       blank;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/seg2hex.sv
// Combinational active-low segment pattern to hex nibble decoder.
// Zero latency; no flow control. Blank and unknown patterns decode to nibble 0.
module seg2hex
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output dec_t       dec
);

    always_comb begin
        dec = '0;
        case (seg)
            SEG_0:     dec.nib = 4'h0;
            SEG_1:     dec.nib = 4'h1;
            SEG_2:     dec.nib = 4'h2;
            SEG_3:     dec.nib = 4'h3;
            SEG_4:     dec.nib = 4'h4;
            SEG_5:     dec.nib = 4'h5;
            SEG_6:     dec.nib = 4'h6;
            SEG_7:     dec.nib = 4'h7;
            SEG_8:     dec.nib = 4'h8;
            SEG_9:     dec.nib = 4'h9;
            SEG_A:     dec.nib = 4'hA;
            SEG_B:     dec.nib = 4'hB;
            SEG_C:     dec.nib = 4'hC;
            SEG_D:     dec.nib = 4'hD;
            SEG_E:     dec.nib = 4'hE;
            SEG_F:     dec.nib = 4'hF;
            SEG_BLANK: dec.blank = 1'b1;
            default:   dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Reconstructs the hex value shown on a scanned active-low 7-seg bus, one value per full round.
// Digit captured after SETTLE stable cycles past the input register; publish one cycle after the completing capture.
module seg_scan_capture
    import seg7_pkg::*;
#(
    parameter int NDIG   = 4,
    parameter int SETTLE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          segs_n,
    input  logic [NDIG-1:0]     an_n,
    output logic [4*NDIG-1:0]   value,
    output logic                value_valid,
    output logic                round_err,
    output logic [NDIG-1:0]     blank_mask,
    output logic                pattern_err
);

    localparam int CW = $clog2(SETTLE + 1);
    localparam int IW = $clog2(NDIG);

    logic [6:0]        seg_q, seg_p;
    logic [NDIG-1:0]   an_q, an_p;
    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [4*NDIG-1:0] slots, slots_new;
    logic [NDIG-1:0]   mask, mask_new;
    logic [NDIG-1:0]   blank_acc, blank_new;
    logic              err_acc, err_new;
    logic              stable, onehot, capture, done;
    logic [IW-1:0]     sel;
    dec_t              dec;

    seg2hex u_seg2hex (
        .seg (seg_q),
        .dec (dec)
    );

    assign stable  = (an_q == an_p) && (seg_q == seg_p);
    assign onehot  = $onehot(~an_q);
    assign capture = (state == ST_CAPTURE);

    always_comb begin
        sel = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (!an_q[i]) sel = IW'(i);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_WAIT: begin
                if (onehot) begin
                    state_nxt = ST_SETTLE;
                    cnt_nxt   = CW'(1);
                end else begin
                    cnt_nxt   = '0;
                end
            end
            ST_SETTLE: begin
                if (!stable || !onehot) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = '0;
                end else begin
                    if (cnt != CW'(SETTLE)) cnt_nxt = cnt + CW'(1);
                    if (int'(cnt) + 1 >= SETTLE) state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: state_nxt = ST_DWELL;
            ST_DWELL: begin
                // Wait for the scan to move on before the next digit can settle.
                if (!stable) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_WAIT;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        slots_new                   = slots;
        slots_new[4*int'(sel) +: 4] = dec.nib;
        mask_new                    = mask;
        mask_new[sel]               = 1'b1;
        blank_new                   = blank_acc;
        blank_new[sel]              = dec.blank;
        err_new                     = err_acc | dec.illegal;
        done                        = capture && (&mask_new);
    end

    assign pattern_err = capture && dec.illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q       <= '1;
            an_q        <= '1;
            seg_p       <= '1;
            an_p        <= '1;
            state       <= ST_WAIT;
            cnt         <= '0;
            slots       <= '0;
            mask        <= '0;
            blank_acc   <= '0;
            err_acc     <= 1'b0;
            value       <= '0;
            value_valid <= 1'b0;
            round_err   <= 1'b0;
            blank_mask  <= '0;
        end else begin
            seg_q       <= segs_n;
            an_q        <= an_n;
            seg_p       <= seg_q;
            an_p        <= an_q;
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            value_valid <= done;
            if (capture) begin
                slots <= slots_new;
                if (done) begin
                    value      <= slots_new;
                    round_err  <= err_new;
                    blank_mask <= blank_new;
                    mask       <= '0;
                    blank_acc  <= '0;
                    err_acc    <= 1'b0;
                end else begin
                    mask       <= mask_new;
                    blank_acc  <= blank_new;
                    err_acc    <= err_new;
                end
            end
        end
    end

endmodule
